uart_rx_frame: RTL and testbench

- UART receiver that is the line-side counterpart of the team's multi-byte UART transmitter.
- Samples the serial line at 8N1 and assembles MEMORY_LENGTH consecutive bytes into one word. Byte k occupies bits [8k+7:8k], the same ordering the transmitter uses when it serialises dataToSend.
- Presents the completed word with a valid/ack handshake to the CPU-side consumer.
- Flags framing errors, overruns and inter-byte timeouts.

---
 rtl/uart_rx_frame.sv | 175 +++++++++++++++++
 tb/tb_uart_rx_frame.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver that assembles MEMORY_LENGTH bytes into one word (byte k at [8k+7:8k])
// and hands completed words to the consumer over a valid/ack handshake.
//
// state | meaning
// IDLE  | line high, waiting for a start edge; runs the inter-byte timeout mid-word
// START | confirming the start bit at its midpoint (glitch filter)
// DATA  | sampling 8 data bits LSB-first at mid-bit
// STOP  | sampling the stop bit at its midpoint; commits the byte or flags framing
// BREAK | after a framing error, waiting for the line to return high
module uart_rx_frame #(
   parameter int DELAY_FRAMES   = 234,
   parameter int MEMORY_LENGTH  = 4,
   parameter int TIMEOUT_CYCLES = 4680
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       uart_rx,
   output logic [MEMORY_LENGTH*8-1:0] data_received,
   output logic                       data_valid,
   input  logic                       data_ack,
   output logic                       framing_error,
   output logic                       overrun
);

   localparam int WORD_W = MEMORY_LENGTH * 8;
   localparam int HALF   = DELAY_FRAMES / 2;
   localparam int CNT_W  = ($clog2(DELAY_FRAMES + 1) > 16) ? $clog2(DELAY_FRAMES + 1) : 16;
   localparam int TO_W   = ($clog2(TIMEOUT_CYCLES + 1) > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   localparam logic [CNT_W:0]  HALF_TC   = (CNT_W + 1)'(HALF);
   localparam logic [CNT_W:0]  BIT_TC    = (CNT_W + 1)'(DELAY_FRAMES);
   localparam logic [CNT_W:0]  CNT_ONE   = (CNT_W + 1)'(1);
   localparam logic [TO_W-1:0] TO_TC     = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TO_W-1:0] TO_ONE    = TO_W'(1);
   localparam logic [3:0]      LAST_BYTE = 4'(MEMORY_LENGTH - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } stateT;

   stateT             state;
   logic              rxMeta;
   logic              rxS;
   logic [CNT_W-1:0]  bitCnt;
   logic [CNT_W:0]    bitCntNext;
   logic [TO_W-1:0]   timeoutCnt;
   logic [2:0]        bitNum;
   logic [3:0]        byteIdx;
   logic [7:0]        shiftReg;
   logic [WORD_W-1:0] wordBuf;
   logic [WORD_W-1:0] mergedWord;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rxMeta <= 1'b1;
         rxS    <= 1'b1;
      end else begin
         rxMeta <= uart_rx;
         rxS    <= rxMeta;
      end
   end

   // one bit wider than the counter so the +1 compare never wraps
   assign bitCntNext = {1'b0, bitCnt} + CNT_ONE;

   // the final byte is merged here so the word can be published on the stop-bit edge
   always_comb begin
      mergedWord = wordBuf;
      mergedWord[{byteIdx, 3'b000} +: 8] = shiftReg;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         bitCnt        <= '0;
         timeoutCnt    <= '0;
         bitNum        <= '0;
         byteIdx       <= '0;
         shiftReg      <= '0;
         wordBuf       <= '0;
         data_received <= '0;
         data_valid    <= 1'b0;
         framing_error <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         framing_error <= 1'b0;
         overrun       <= 1'b0;
         if (data_valid && data_ack) begin
            data_valid <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (!rxS) begin
                  state      <= START;
                  bitCnt     <= '0;
                  timeoutCnt <= '0;
               end else if (byteIdx != 4'd0) begin
                  if (timeoutCnt == TO_TC) begin
                     byteIdx    <= '0;
                     timeoutCnt <= '0;
                  end else begin
                     timeoutCnt <= timeoutCnt + TO_ONE;
                  end
               end
            end

            START: begin
               if (bitCntNext == HALF_TC) begin
                  bitCnt <= '0;
                  if (!rxS) begin
                     state  <= DATA;
                     bitNum <= '0;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  bitCnt <= bitCntNext[CNT_W-1:0];
               end
            end

            DATA: begin
               if (bitCntNext == BIT_TC) begin
                  bitCnt   <= '0;
                  shiftReg <= {rxS, shiftReg[7:1]};
                  if (bitNum == 3'd7) begin
                     state <= STOP;
                  end else begin
                     bitNum <= bitNum + 3'd1;
                  end
               end else begin
                  bitCnt <= bitCntNext[CNT_W-1:0];
               end
            end

            STOP: begin
               if (bitCntNext == BIT_TC) begin
                  bitCnt <= '0;
                  if (rxS) begin
                     wordBuf[{byteIdx, 3'b000} +: 8] <= shiftReg;
                     state <= IDLE;
                     if (byteIdx == LAST_BYTE) begin
                        data_received <= mergedWord;
                        data_valid    <= 1'b1;
                        overrun       <= data_valid && !data_ack;
                        byteIdx       <= '0;
                     end else begin
                        byteIdx <= byteIdx + 4'd1;
                     end
                  end else begin
                     framing_error <= 1'b1;
                     byteIdx       <= '0;
                     state         <= BREAK;
                  end
               end else begin
                  bitCnt <= bitCntNext[CNT_W-1:0];
               end
            end

            BREAK: begin
               if (rxS) begin
                  state <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: vector table of words, hand sequences for glitch/framing/overrun/
// timeout/reset, then random byte streams checked against a transaction-level word model.
module tb_uart_rx_frame;

   localparam int D    = 16;
   localparam int ML   = 4;
   localparam int TO   = 320;
   localparam int HALF = D / 2;
   localparam int CLKP = 10;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        uart_rx = 1'b1;
   logic        data_ack = 1'b0;
   logic [31:0] data_received;
   logic        data_valid;
   logic        framing_error;
   logic        overrun;

   uart_rx_frame #(
      .DELAY_FRAMES(D),
      .MEMORY_LENGTH(ML),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .uart_rx(uart_rx),
      .data_received(data_received),
      .data_valid(data_valid),
      .data_ack(data_ack),
      .framing_error(framing_error),
      .overrun(overrun)
   );

   always #(CLKP / 2) clk = ~clk;

   int          nCompared = 0;
   int          nMismatched = 0;
   int          riseCnt = 0;
   int          feCnt = 0;
   int          ovCnt = 0;
   logic        prevValid = 1'b0;
   logic [31:0] capQ[$];
   time         riseTime = 0;
   time         lastStart = 0;

   // completions are a rise of data_valid or an overwrite flagged by overrun
   always @(negedge clk) begin
      if (!rst_n) begin
         prevValid = 1'b0;
      end else begin
         if (data_valid && !prevValid) begin
            riseCnt++;
            riseTime = $time;
            capQ.push_back(data_received);
         end else if (overrun) begin
            capQ.push_back(data_received);
         end
         if (framing_error) feCnt++;
         if (overrun) ovCnt++;
         prevValid = data_valid;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic checkRange(input string name, input int act, input int lo, input int hi);
      nCompared++;
      if (act < lo || act > hi) begin
         nMismatched++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic sendByte(input logic [7:0] b, input logic stopBit);
      lastStart = $time;
      uart_rx = 1'b0;
      repeat (D) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (D) @(negedge clk);
      end
      uart_rx = stopBit;
      repeat (D) @(negedge clk);
      uart_rx = 1'b1;
   endtask

   task automatic sendWord(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
      sendByte(b0, 1'b1);
      sendByte(b1, 1'b1);
      sendByte(b2, 1'b1);
      sendByte(b3, 1'b1);
   endtask

   task automatic ackPulse();
      data_ack = 1'b1;
      @(negedge clk);
      data_ack = 1'b0;
   endtask

   typedef struct {
      logic [7:0]  b0;
      logic [7:0]  b1;
      logic [7:0]  b2;
      logic [7:0]  b3;
      logic [31:0] exp;
   } vecT;

   vecT vecs[5];

   int          r0, f0, o0, capStart, gap;
   logic [7:0]  rb;
   logic        bad;
   logic [31:0] expQ[$];
   logic [7:0]  partial[$];
   logic [31:0] w;
   logic        validExp;
   int          feExp, ovExp;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{8'h00, 8'hFF, 8'h00, 8'hFF, 32'hFF00FF00};
      vecs[1] = '{8'h12, 8'h34, 8'h56, 8'h78, 32'h78563412};
      vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 32'hFFFFFFFF};
      vecs[3] = '{8'h80, 8'h01, 8'h7E, 8'hC3, 32'hC37E0180};
      vecs[4] = '{8'h00, 8'h00, 8'h00, 8'h00, 32'h00000000};

      repeat (3) @(negedge clk);
      #1;
      check("reset data_received", data_received, 32'h0);
      check("reset data_valid", 32'(data_valid), 32'h0);
      check("reset framing_error", 32'(framing_error), 32'h0);
      check("reset overrun", 32'(overrun), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // back-to-back word, latency and ack
      r0 = riseCnt; f0 = feCnt; o0 = ovCnt;
      sendWord(8'h44, 8'h33, 8'h22, 8'h11);
      #1;
      check("t1 word", data_received, 32'h11223344);
      check("t1 valid", 32'(data_valid), 32'h1);
      check("t1 rises", 32'(riseCnt - r0), 32'd1);
      check("t1 framing", 32'(feCnt - f0), 32'd0);
      check("t1 overrun", 32'(ovCnt - o0), 32'd0);
      checkRange("t1 latency", int'((riseTime - lastStart) / CLKP), HALF + 9 * D + 2, HALF + 9 * D + 4);
      @(negedge clk);
      ackPulse();
      #1;
      check("t1 valid after ack", 32'(data_valid), 32'h0);

      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         sendWord(vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].b3);
         #1;
         check($sformatf("vec%0d word", i), data_received, vecs[i].exp);
         check($sformatf("vec%0d valid", i), 32'(data_valid), 32'h1);
         @(negedge clk);
         ackPulse();
         #1;
         check($sformatf("vec%0d acked", i), 32'(data_valid), 32'h0);
      end

      // short low glitch on idle line
      @(negedge clk);
      r0 = riseCnt; f0 = feCnt;
      uart_rx = 1'b0;
      repeat (3) @(negedge clk);
      uart_rx = 1'b1;
      repeat (40) @(negedge clk);
      #1;
      check("t2 no rise", 32'(riseCnt - r0), 32'd0);
      check("t2 no framing", 32'(feCnt - f0), 32'd0);
      check("t2 valid low", 32'(data_valid), 32'h0);
      @(negedge clk);
      sendWord(8'hA5, 8'hA5, 8'hA5, 8'hA5);
      #1;
      check("t2 word", data_received, 32'hA5A5A5A5);
      check("t2 rises", 32'(riseCnt - r0), 32'd1);
      @(negedge clk);
      ackPulse();

      // bad stop bit in byte 2 discards the partial word
      r0 = riseCnt; f0 = feCnt;
      sendByte(8'hAA, 1'b1);
      sendByte(8'hBB, 1'b1);
      sendByte(8'hCC, 1'b0);
      repeat (40) @(negedge clk);
      sendWord(8'h01, 8'h02, 8'h03, 8'h04);
      #1;
      check("t3 framing pulses", 32'(feCnt - f0), 32'd1);
      check("t3 word", data_received, 32'h04030201);
      check("t3 rises", 32'(riseCnt - r0), 32'd1);
      @(negedge clk);
      ackPulse();

      // two words without ack
      o0 = ovCnt;
      sendWord(8'h10, 8'h20, 8'h30, 8'h40);
      #1;
      check("t4 first word", data_received, 32'h40302010);
      check("t4 no overrun yet", 32'(ovCnt - o0), 32'd0);
      @(negedge clk);
      sendWord(8'hC0, 8'hB0, 8'hA0, 8'h90);
      #1;
      check("t4 overrun pulses", 32'(ovCnt - o0), 32'd1);
      check("t4 second word", data_received, 32'h90A0B0C0);
      check("t4 valid held", 32'(data_valid), 32'h1);
      @(negedge clk);
      ackPulse();

      // inter-byte timeout
      r0 = riseCnt;
      sendByte(8'h55, 1'b1);
      sendByte(8'h66, 1'b1);
      repeat (TO + 80) @(negedge clk);
      sendWord(8'hDE, 8'hAD, 8'hBE, 8'hEF);
      #1;
      check("t5 word", data_received, 32'hEFBEADDE);
      check("t5 rises", 32'(riseCnt - r0), 32'd1);
      @(negedge clk);
      ackPulse();

      // asynchronous reset mid-frame
      sendWord(8'h0F, 8'h1E, 8'h2D, 8'h3C);
      sendByte(8'h99, 1'b1);
      uart_rx = 1'b0;
      repeat (D) @(negedge clk);
      uart_rx = 1'b1; repeat (D) @(negedge clk);
      uart_rx = 1'b0; repeat (D) @(negedge clk);
      uart_rx = 1'b1; repeat (D) @(negedge clk);
      check("t6 valid before reset", 32'(data_valid), 32'h1);
      check("t6 word before reset", data_received, 32'h3C2D1E0F);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6 async data_received", data_received, 32'h0);
      check("t6 async data_valid", 32'(data_valid), 32'h0);
      check("t6 async framing", 32'(framing_error), 32'h0);
      check("t6 async overrun", 32'(overrun), 32'h0);
      uart_rx = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      sendWord(8'h5A, 8'hC3, 8'h3C, 8'hA5);
      #1;
      check("t6 fresh word", data_received, 32'hA53CC35A);
      check("t6 fresh valid", 32'(data_valid), 32'h1);
      @(negedge clk);
      ackPulse();

      // random byte stream against the word-level model
      repeat (4) @(negedge clk);
      capStart = capQ.size();
      f0 = feCnt; o0 = ovCnt;
      validExp = 1'b0; feExp = 0; ovExp = 0;
      for (int n = 0; n < 48; n++) begin
         rb  = 8'($urandom_range(0, 255));
         bad = ($urandom_range(0, 9) == 0);
         sendByte(rb, !bad);
         if (bad) begin
            feExp++;
            partial.delete();
            gap = 32 + $urandom_range(0, 16);
         end else begin
            partial.push_back(rb);
            if (partial.size() == ML) begin
               w = '0;
               for (int k = 0; k < ML; k++) w[8*k +: 8] = partial[k];
               expQ.push_back(w);
               if (validExp) ovExp++;
               validExp = 1'b1;
               partial.delete();
            end
            case ($urandom_range(0, 9))
               0:             begin gap = TO + 60; partial.delete(); end
               1, 2, 3, 4:    gap = 0;
               default:       gap = $urandom_range(1, 30);
            endcase
         end
         if ($urandom_range(0, 2) == 0) begin
            ackPulse();
            validExp = 1'b0;
         end
         repeat (gap) @(negedge clk);
      end
      repeat (5) @(negedge clk);
      #1;
      check("rand word count", 32'(capQ.size() - capStart), 32'(expQ.size()));
      for (int i = 0; i < expQ.size() && capStart + i < capQ.size(); i++)
         check($sformatf("rand word %0d", i), capQ[capStart + i], expQ[i]);
      check("rand framing count", 32'(feCnt - f0), 32'(feExp));
      check("rand overrun count", 32'(ovCnt - o0), 32'(ovExp));
      check("rand final valid", 32'(data_valid), 32'(validExp));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
